// File: rtl/uart_rx_16x_if.sv
// Byte-delivery handshake between uart_rx_16x and its consumer.
// The receiver (master) presents rx_data/rx_valid; the consumer (slave)
// answers with rx_ready. rx_data is held stable while rx_valid is high.
interface uart_rx_16x_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 16x-oversampling UART receiver fed by baud_gen_16x.
// Samples each bit at its middle tick, deframes LSB-first frames of
// DATA_BITS data bits and one stop bit, and hands bytes out over a
// valid/ready interface. frame_err, overrun_err and parity_err are
// single-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data bits (even, or odd when
//               PARITY_ODD=1); a mismatch pulses parity_err while the
//               byte is still delivered.
//   undefined : no parity bit in the frame; parity_err is constant 0.
module uart_rx_16x #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          baud_tick_16x,
  input  logic          rx,
  uart_rx_16x_if.master rx_bus,
  output logic          frame_err,
  output logic          overrun_err,
  output logic          parity_err,
  output logic          busy
);

  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
  localparam logic       PAR_ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t                 state_q,       state_d;
  logic [SYNC_STAGES-1:0] sync_q,        sync_d;
  logic [3:0]             tick_cnt_q,    tick_cnt_d;
  logic [2:0]             bit_cnt_q,     bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q,       shreg_d;
  logic [DATA_BITS-1:0]   rx_data_q,     rx_data_d;
  logic                   rx_valid_q,    rx_valid_d;
  logic                   frame_err_q,   frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   busy_q,        busy_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q,     par_bad_d;
  logic                   parity_err_q,  parity_err_d;
`endif

  logic rx_s;
  logic deliver;

  // The last synchronizer stage is the only copy of rx the FSM may look at.
  assign rx_s = sync_q[SYNC_STAGES-1];

  // Next-state logic: synchronizer shift, frame FSM, and the output handshake.
  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[SYNC_STAGES-2:0], rx};
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_bus.rx_ready;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    deliver       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif

    if (baud_tick_16x) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d    = S_START;
            tick_cnt_d = 4'd0;
          end
        end

        S_START: begin
          if (tick_cnt_q == 4'd7) begin
            if (!rx_s) begin
              state_d    = S_DATA;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end

        S_DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            par_bad_d = rx_s ^ (^shreg_q) ^ PAR_ODD_BIT;
            state_d   = S_STOP;
          end
        end
`endif

        S_STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (rx_s) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_HI;
            end
          end
        end

        S_WAIT_HI: begin
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // A byte is accepted only if the output slot is free or being drained now.
    if (deliver) begin
      if (!rx_valid_q || rx_bus.rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = par_bad_q;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  // All state and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sync_q        <= '1;
      tick_cnt_q    <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_bus.rx_data  = rx_data_q;
  assign rx_bus.rx_valid = rx_valid_q;
  assign frame_err       = frame_err_q;
  assign overrun_err     = overrun_err_q;
  assign busy            = busy_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  // Without a parity bit the parity sense has nothing to act on.
  assign parity_err = PAR_ODD_BIT & 1'b0;
`endif

endmodule
